// File: rtl/system_datapath.sv
// Mini-SRC style CPU datapath: single shared bus, register file, ALU with
// 64-bit Z, CON flip-flop and a 512x32 memory.  Every control line comes from
// outside.  A backdoor port preloads memory words.
module system_datapath #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  Clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] inport_data,
  input  logic                  inport_data_ready,
  output logic [DATA_WIDTH-1:0] outport_data,
  input  logic                  outport_in,
  input  logic                  HIout,
  input  logic                  LOout,
  input  logic                  Zhi_out,
  input  logic                  Zlo_out,
  input  logic                  PCout,
  input  logic                  MDRout,
  input  logic                  Inport_out,
  input  logic                  Cout,
  input  logic                  MARin,
  input  logic                  Zin,
  input  logic                  PCin,
  input  logic                  MDRin,
  input  logic                  IRin,
  input  logic                  Yin,
  input  logic                  HIin,
  input  logic                  LOin,
  input  logic                  CONin,
  input  logic [4:0]            opcode,
  input  logic                  IncPC,
  input  logic                  Gra,
  input  logic                  Grb,
  input  logic                  Grc,
  input  logic                  Rin,
  input  logic                  Rout,
  input  logic                  BAout,
  output logic                  con_ff_bit,
  input  logic                  Mem_Read,
  input  logic                  Mem_Write,
  input  logic                  Mem_enable512x32,
  output logic [DATA_WIDTH-1:0] Mem_to_datapath_out,
  output logic [DATA_WIDTH-1:0] Mem_data_to_chip_out,
  output logic [ADDR_WIDTH-1:0] MAR_address_out,
  input  logic                  mem_overide,
  input  logic [ADDR_WIDTH-1:0] overide_address,
  input  logic [DATA_WIDTH-1:0] overide_data_in
);
  localparam int DW = DATA_WIDTH;

  logic [DW-1:0] r_q [16];
  logic [DW-1:0] pc_q, ir_q, mar_q, mdr_q, y_q, zhi_q, zlo_q, hi_q, lo_q;
  logic [DW-1:0] inport_q, outport_q;
  logic          con_q;
  logic [DW-1:0] mem [2**ADDR_WIDTH];

  logic [3:0]      sel_idx;
  logic [DW-1:0]   bus, c_sext, mem_rd, mdr_d;
  logic [2*DW-1:0] z_d;
  logic            con_d;

  // Register index chosen from the IR field named by Gra/Grb/Grc.
  assign sel_idx = Gra ? ir_q[26:23] : Grb ? ir_q[22:19] : Grc ? ir_q[18:15] : 4'd0;
  assign c_sext  = {{(DW-19){ir_q[18]}}, ir_q[18:0]};

  // Bus source mux, fixed priority; BAout reads R0 as zero.
  always_comb begin
    bus = '0;
    if (Rout || BAout)  bus = (BAout && sel_idx == 4'd0) ? '0 : r_q[sel_idx];
    else if (PCout)     bus = pc_q;
    else if (MDRout)    bus = mdr_q;
    else if (Zhi_out)   bus = zhi_q;
    else if (Zlo_out)   bus = zlo_q;
    else if (HIout)     bus = hi_q;
    else if (LOout)     bus = lo_q;
    else if (Inport_out) bus = inport_q;
    else if (Cout)      bus = c_sext;
  end

  // ALU: A = Y, B = bus; 64-bit result destined for Zhi:Zlo.
  logic [4:0]        sh;
  logic [2*DW-1:0]   rot_r, rot_l, prod;
  logic signed [DW-1:0] a_s, b_s, b_safe, quo, rem;
  assign sh     = bus[4:0];
  assign rot_r  = {y_q, y_q} >> sh;
  assign rot_l  = {y_q, y_q} << sh;
  assign prod   = {{DW{y_q[DW-1]}}, y_q} * {{DW{bus[DW-1]}}, bus};
  assign a_s    = y_q;
  assign b_s    = bus;
  // Divisor forced to 1 on zero so the divider never sees /0; result is masked.
  assign b_safe = (bus == '0) ? 1 : b_s;
  assign quo    = a_s / b_safe;
  assign rem    = a_s % b_safe;

  // Opcode decode; IncPC overrides the opcode for PC increment.
  always_comb begin
    z_d = {{DW{1'b0}}, bus};
    if (IncPC) z_d = {{DW{1'b0}}, bus + 1'b1};
    else begin
      unique case (opcode)
        5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01100:
                  z_d = {{DW{1'b0}}, y_q + bus};
        5'b00100: z_d = {{DW{1'b0}}, y_q - bus};
        5'b00101, 5'b01101: z_d = {{DW{1'b0}}, y_q & bus};
        5'b00110, 5'b01110: z_d = {{DW{1'b0}}, y_q | bus};
        5'b00111: z_d = {{DW{1'b0}}, rot_r[DW-1:0]};
        5'b01000: z_d = {{DW{1'b0}}, rot_l[2*DW-1:DW]};
        5'b01001: z_d = {{DW{1'b0}}, y_q >> sh};
        5'b01010: z_d = {{DW{1'b0}}, a_s >>> sh};
        5'b01011: z_d = {{DW{1'b0}}, y_q << sh};
        5'b01111: z_d = (bus == '0) ? '0 : {rem, quo};
        5'b10000: z_d = prod;
        5'b10001: z_d = {{DW{1'b0}}, -bus};
        5'b10010: z_d = {{DW{1'b0}}, ~bus};
        default:  z_d = {{DW{1'b0}}, bus};
      endcase
    end
  end

  // Branch condition evaluated on the bus, mode from IR[20:19].
  always_comb begin
    unique case (ir_q[20:19])
      2'b00:   con_d = (bus == '0);
      2'b01:   con_d = (bus != '0);
      2'b10:   con_d = ~bus[DW-1];
      default: con_d = bus[DW-1];
    endcase
  end

  assign mem_rd = (Mem_Read && Mem_enable512x32) ? mem[mar_q[ADDR_WIDTH-1:0]] : '0;
  assign mdr_d  = Mem_Read ? mem_rd : bus;

  // Datapath registers; clear wins over every load enable.
  always_ff @(posedge Clock) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      pc_q <= '0; ir_q <= '0; mar_q <= '0; mdr_q <= '0; y_q <= '0;
      zhi_q <= '0; zlo_q <= '0; hi_q <= '0; lo_q <= '0;
      inport_q <= '0; outport_q <= '0; con_q <= 1'b0;
    end else begin
      if (Rin)               r_q[sel_idx] <= bus;
      if (PCin)              pc_q      <= bus;
      if (IRin)              ir_q      <= bus;
      if (MARin)             mar_q     <= bus;
      if (MDRin)             mdr_q     <= mdr_d;
      if (Yin)               y_q       <= bus;
      if (Zin)               {zhi_q, zlo_q} <= z_d;
      if (HIin)              hi_q      <= bus;
      if (LOin)              lo_q      <= bus;
      if (inport_data_ready) inport_q  <= inport_data;
      if (outport_in)        outport_q <= bus;
      if (CONin)             con_q     <= con_d;
    end
  end

  // Memory write port; the backdoor is held across an edge and masks normal writes.
  always_ff @(posedge Clock) begin
    if (mem_overide && Mem_enable512x32)
      mem[overide_address] <= overide_data_in;
    else if (Mem_Write && Mem_enable512x32)
      mem[mar_q[ADDR_WIDTH-1:0]] <= mdr_q;
  end

  assign outport_data         = outport_q;
  assign con_ff_bit           = con_q;
  assign Mem_to_datapath_out  = mem_rd;
  assign Mem_data_to_chip_out = mdr_q;
  assign MAR_address_out      = mar_q[ADDR_WIDTH-1:0];

  logic unused_bits;
  assign unused_bits = ^{ir_q[DW-1:27], mar_q[DW-1:ADDR_WIDTH]};
endmodule

// File: tb/tb_system_datapath.sv
// Directed bench for system_datapath: stimulus pushes expected values into a
// scoreboard queue; a negedge monitor pops and compares against DUT outputs.
module tb_system_datapath;
  logic        Clock = 1'b0;
  logic        clear;
  logic [31:0] inport_data;
  logic        inport_data_ready;
  logic [31:0] outport_data;
  logic        outport_in, HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin;
  logic [4:0]  opcode;
  logic        IncPC, Gra, Grb, Grc, Rin, Rout, BAout;
  logic        con_ff_bit;
  logic        Mem_Read, Mem_Write, Mem_enable512x32;
  logic [31:0] Mem_to_datapath_out, Mem_data_to_chip_out;
  logic [8:0]  MAR_address_out;
  logic        mem_overide;
  logic [8:0]  overide_address;
  logic [31:0] overide_data_in;

  system_datapath dut (
    .Clock(Clock), .clear(clear), .inport_data(inport_data), .inport_data_ready(inport_data_ready),
    .outport_data(outport_data), .outport_in(outport_in), .HIout(HIout), .LOout(LOout),
    .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .PCout(PCout), .MDRout(MDRout), .Inport_out(Inport_out),
    .Cout(Cout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .CONin(CONin), .opcode(opcode), .IncPC(IncPC), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .con_ff_bit(con_ff_bit), .Mem_Read(Mem_Read),
    .Mem_Write(Mem_Write), .Mem_enable512x32(Mem_enable512x32), .Mem_to_datapath_out(Mem_to_datapath_out),
    .Mem_data_to_chip_out(Mem_data_to_chip_out), .MAR_address_out(MAR_address_out),
    .mem_overide(mem_overide), .overide_address(overide_address), .overide_data_in(overide_data_in)
  );

  always #5 Clock = ~Clock;

  typedef struct { string name; logic [31:0] exp; int sel; } exp_t;
  exp_t sb[$];
  logic obs_vld = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Monitor: sel 0 outport, 1 CON, 2 memory read data, 3 MAR address, 4 MDR to memory.
  always @(negedge Clock) begin
    exp_t e;
    logic [31:0] act;
    if (obs_vld) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underflow: nothing expected");
      end else begin
        e = sb.pop_front();
        case (e.sel)
          0:       act = outport_data;
          1:       act = {31'b0, con_ff_bit};
          2:       act = Mem_to_datapath_out;
          3:       act = {23'b0, MAR_address_out};
          default: act = Mem_data_to_chip_out;
        endcase
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic clr_ctl();
    clear = 0; inport_data_ready = 0; outport_in = 0; HIout = 0; LOout = 0; Zhi_out = 0;
    Zlo_out = 0; PCout = 0; MDRout = 0; Inport_out = 0; Cout = 0; MARin = 0; Zin = 0; PCin = 0;
    MDRin = 0; IRin = 0; Yin = 0; HIin = 0; LOin = 0; CONin = 0; opcode = 5'd0; IncPC = 0;
    Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0; Mem_Read = 0; Mem_Write = 0;
    Mem_enable512x32 = 0; mem_overide = 0;
  endtask

  task automatic tick();
    @(posedge Clock); #1; clr_ctl();
  endtask

  task automatic chk(string n, logic [31:0] v, int sel);
    exp_t e;
    e.name = n; e.exp = v; e.sel = sel;
    sb.push_back(e);
    obs_vld = 1'b1;
    @(negedge Clock); #1;
    obs_vld = 1'b0;
  endtask

  // Caller selects the bus source; this latches it into the outport and checks.
  task automatic outchk(string n, logic [31:0] v);
    outport_in = 1; tick(); chk(n, v, 0);
  endtask

  task automatic set_in(logic [31:0] v);
    inport_data = v; inport_data_ready = 1; tick();
  endtask

  task automatic fetch();
    PCout = 1; IncPC = 1; MARin = 1; Zin = 1; tick();
    Zlo_out = 1; PCin = 1; MDRin = 1; Mem_Read = 1; Mem_enable512x32 = 1; tick();
    MDRout = 1; IRin = 1; tick();
  endtask

  task automatic setir(logic [31:0] v);
    set_in(v); Inport_out = 1; MDRin = 1; tick();
    MDRout = 1; IRin = 1; tick();
  endtask

  task automatic alu(string n, logic [31:0] a, logic [31:0] b, logic [4:0] op, logic inc,
                     logic [31:0] zlo, logic [31:0] zhi);
    set_in(a); Inport_out = 1; Yin = 1; tick();
    set_in(b); Inport_out = 1; opcode = op; IncPC = inc; Zin = 1; tick();
    Zlo_out = 1; outchk({n, "_zlo"}, zlo);
    Zhi_out = 1; outchk({n, "_zhi"}, zhi);
  endtask

  task automatic preload(logic [8:0] a, logic [31:0] d);
    mem_overide = 1; Mem_enable512x32 = 1; overide_address = a; overide_data_in = d; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    inport_data = 0; overide_address = 0; overide_data_in = 0;
    clr_ctl();
    clear = 1; tick();
    chk("rst_outport", 32'h0, 0);
    chk("rst_con", 32'h0, 1);
    PCout = 1; outchk("rst_pc", 32'h0);

    preload(9'd0, 32'hB1800000);
    preload(9'd1, 32'hB9800000);

    // First fetch: PC -> 1, IR = in r3
    fetch();
    PCout = 1; outchk("fetch0_pc", 32'h1);
    MDRout = 1; outchk("fetch0_mdr", 32'hB1800000);
    set_in(32'd5); Inport_out = 1; Gra = 1; Rin = 1; tick();
    Gra = 1; Rout = 1; outchk("in_r3", 32'd5);

    // Second fetch: out r3
    fetch();
    Gra = 1; Rout = 1; outchk("out_r3", 32'd5);
    PCout = 1; outchk("fetch1_pc", 32'h2);

    alu("add", 32'd7, 32'd3, 5'b00011, 1'b0, 32'd10, 32'd0);
    alu("sub", 32'd7, 32'd3, 5'b00100, 1'b0, 32'd4, 32'd0);
    alu("mul", 32'hFFFFFFFE, 32'd3, 5'b10000, 1'b0, 32'hFFFFFFFA, 32'hFFFFFFFF);
    alu("div", 32'd7, 32'd3, 5'b01111, 1'b0, 32'd2, 32'd1);
    alu("div0", 32'd7, 32'd0, 5'b01111, 1'b0, 32'd0, 32'd0);
    alu("ror", 32'h80000001, 32'd1, 5'b00111, 1'b0, 32'hC0000000, 32'd0);
    alu("shra", 32'h80000001, 32'd4, 5'b01010, 1'b0, 32'hF8000000, 32'd0);
    alu("neg", 32'd9, 32'd3, 5'b10001, 1'b0, 32'hFFFFFFFD, 32'd0);
    alu("incpc", 32'd9, 32'd3, 5'b00100, 1'b1, 32'd4, 32'd0);

    // CON: IR = B9800000 gives mode 00 (bus == 0)
    CONin = 1; tick(); chk("con_eq0_bus0", 32'd1, 1);
    set_in(32'd1); Inport_out = 1; CONin = 1; tick(); chk("con_eq0_bus1", 32'd0, 1);
    setir(32'h000C0000);
    set_in(32'd1); Inport_out = 1; CONin = 1; tick(); chk("con_ne0_bus1", 32'd1, 1);

    // R0 = 9, BAout reads it as zero
    set_in(32'd9); Inport_out = 1; Gra = 1; Rin = 1; tick();
    Gra = 1; BAout = 1; outchk("baout_r0", 32'd0);
    Gra = 1; Rout = 1; outchk("rout_r0", 32'd9);
    Cout = 1; outchk("c_sext", 32'hFFFC0000);
    outchk("bus_idle", 32'd0);

    // Normal memory write, then override masking a write
    set_in(32'h20); Inport_out = 1; MARin = 1; tick();
    chk("mar_out", 32'h20, 3);
    set_in(32'hDEADBEEF); Inport_out = 1; MDRin = 1; tick();
    chk("mdr_to_chip", 32'hDEADBEEF, 4);
    Mem_Write = 1; Mem_enable512x32 = 1; tick();
    Mem_Read = 1; Mem_enable512x32 = 1; chk("mem_write", 32'hDEADBEEF, 2); clr_ctl();
    set_in(32'h5555); Inport_out = 1; MDRin = 1; tick();
    mem_overide = 1; Mem_enable512x32 = 1; Mem_Write = 1;
    overide_address = 9'h21; overide_data_in = 32'h1234; tick();
    Mem_Read = 1; Mem_enable512x32 = 1; chk("ovr_masks_write", 32'hDEADBEEF, 2); clr_ctl();
    set_in(32'h21); Inport_out = 1; MARin = 1; tick();
    Mem_Read = 1; Mem_enable512x32 = 1; chk("ovr_wrote", 32'h1234, 2); clr_ctl();
    chk("mem_rd_gated", 32'h0, 2);

    // Clear mid-sequence
    clear = 1; Gra = 1; Rin = 1; PCin = 1; CONin = 1; outport_in = 1; tick();
    chk("clr_outport", 32'h0, 0);
    chk("clr_con", 32'h0, 1);
    Mem_Read = 1; Mem_enable512x32 = 1; chk("clr_mem0_kept", 32'hB1800000, 2); clr_ctl();
    PCout = 1; outchk("clr_pc", 32'h0);
    Cout = 1; outchk("clr_ir", 32'h0);
    setir(32'h01800000);
    Gra = 1; Rout = 1; outchk("clr_r3", 32'h0);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge Clock);
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
